// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for pipe_stage_buf: the default MEM/WB
//               payload layout, its field offsets and the slot-count limit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default payload: RegWrite + ResultSrc + ALUResult + ReadData + PCPlus4 + Rd
  localparam int MEMWB_DATA_W  = 104;
  localparam int RD_LSB        = 0;
  localparam int PCPLUS4_LSB   = 5;
  localparam int READDATA_LSB  = 37;
  localparam int ALURESULT_LSB = 69;
  localparam int RESULTSRC_LSB = 101;
  localparam int REGWRITE_BIT  = 103;

  // Deepest chain supported between two core stages
  localparam int STAGES_MAX    = 4;

  // Field view of the default MEM/WB payload, MSB first
  typedef struct packed {
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
  } memwb_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_slot
// Description : One elastic slot: a main register driving the output plus a
//               skid register that absorbs the entry arriving on the cycle
//               downstream stalls. in_ready is the inverted skid flag, so
//               there is no combinational path from out_ready to in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_slot #(
  parameter int DATA_W = 104
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic w_accept;
  logic w_main_free;

  assign w_accept    = in_valid & ~r_skid_valid;
  assign w_main_free = ~r_main_valid | out_ready;

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

  // Main/skid update; flush kills both entries but leaves data untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      // Skid full implies in_ready=0, so skid and input never compete here
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_data  <= in_data;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_data  <= in_data;
      r_skid_valid <= 1'b1;
    end
  end

endmodule : pipe_skid_slot
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Chain of STAGES elastic skid slots carrying a DATA_W payload
//               with valid/ready handshake and flush. Forward latency is
//               STAGES cycles, capacity 2*STAGES entries, 1 transfer/cycle.
//               Optional macro PIPE_STAGE_BUF_STATS_EN adds saturating
//               stall_cnt / xfer_cnt statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  // Handshake chain: index 0 is the upstream side, index STAGES the output
  logic              w_valid [0:STAGES];
  logic              w_ready [0:STAGES];
  logic [DATA_W-1:0] w_data  [0:STAGES];

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign w_ready[STAGES] = out_ready;
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];

  // Unsupported configurations elaborate to an empty marker block
  if ((STAGES < 1) || (STAGES > STAGES_MAX) || (CNT_W < 1)) begin : g_cfg_unsupported
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
    pipe_skid_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (w_valid[gi]),
      .in_ready  (w_ready[gi]),
      .in_data   (w_data[gi]),
      .out_valid (w_valid[gi+1]),
      .out_ready (w_ready[gi+1]),
      .out_data  (w_data[gi+1])
    );
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic             w_stall;
  logic             w_xfer;

  assign w_stall   = out_valid & ~out_ready;
  assign w_xfer    = out_valid & out_ready;
  assign stall_cnt = r_stall_cnt;
  assign xfer_cnt  = r_xfer_cnt;

  // Saturating statistics; only reset clears them, flush does not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_xfer && (r_xfer_cnt != {CNT_W{1'b1}})) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
    end
  end
`endif

endmodule : pipe_stage_buf
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Self-checking bench for pipe_stage_buf. Two instances share
//               the input drive: u_dut1 (STAGES=1, CNT_W=4) and u_dut2
//               (STAGES=2). Each check targets one instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int DW = 104;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          rdy1, vld1;
  logic [DW-1:0] dat1;
  logic          rdy2, vld2;
  logic [DW-1:0] dat2;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [3:0]    stall1, xfer1;
  logic [15:0]   stall2, xfer2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_buf #(.DATA_W(DW), .STAGES(1), .CNT_W(4)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .in_data   (in_data),
    .out_valid (vld1),
    .out_ready (out_ready),
    .out_data  (dat1)
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    .stall_cnt (stall1),
    .xfer_cnt  (xfer1)
`endif
  );

  pipe_stage_buf #(.DATA_W(DW), .STAGES(2), .CNT_W(16)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy2),
    .in_data   (in_data),
    .out_valid (vld2),
    .out_ready (out_ready),
    .out_data  (dat2)
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    .stall_cnt (stall2),
    .xfer_cnt  (xfer2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       ev;
    logic [7:0] ed;
    logic       erdy;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = {{(DW-8){1'b0}}, d};
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1};
    vt[1]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0};
    vt[2]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0};
    vt[3]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b1};
    vt[4]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b1};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0C, 1'b1};
    vt[6]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
    vt[7]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
    vt[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1};

    // Reset state
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk("rst_vld1", DW'(vld1), DW'(0));
    chk("rst_dat1", dat1, '0);
    chk("rst_vld2", DW'(vld2), DW'(0));
    chk("rst_rdy1", DW'(rdy1), DW'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream with two entries held in the STAGES=1 instance
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h78, 1'b0, 1'b0);
    step();
    chk("pre_rst_vld1", DW'(vld1), DW'(1));
    chk("pre_rst_rdy1", DW'(rdy1), DW'(0));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld1", DW'(vld1), DW'(0));
    chk("async_rst_dat1", dat1, '0);
    chk("async_rst_dat2", dat2, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_vld1", DW'(vld1), DW'(0));
      chk("post_rst_vld2", DW'(vld2), DW'(0));
    end
    chk("post_rst_rdy1", DW'(rdy1), DW'(1));

    // Table: backpressure, simultaneous consume+accept, flush on STAGES=1
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl);
      step();
      chk($sformatf("vec%0d_vld", i), DW'(vld1), DW'(vt[i].ev));
      chk($sformatf("vec%0d_dat", i), dat1, DW'(vt[i].ed));
      chk($sformatf("vec%0d_rdy", i), DW'(rdy1), DW'(vt[i].erdy));
    end

    // Streaming on STAGES=2: value k visible after edge k+1
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(k), 1'b1, 1'b0);
      step();
      chk($sformatf("strm%0d_vld", k), DW'(vld2), DW'(k >= 2));
      if (k >= 2) chk($sformatf("strm%0d_dat", k), dat2, DW'(k - 1));
      chk($sformatf("strm%0d_rdy", k), DW'(rdy2), DW'(1));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("strm_tail_vld", DW'(vld2), DW'(1));
    chk("strm_tail_dat", dat2, DW'(8));
    step();
    chk("strm_drain_vld", DW'(vld2), DW'(0));

    // Flush on STAGES=2 with four entries buffered
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      step();
      chk($sformatf("fill%0d_rdy", k), DW'(rdy2), DW'(k < 4));
    end
    chk("fill_dat", dat2, DW'(1));
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    step();
    chk("flush_vld", DW'(vld2), DW'(0));
    chk("flush_rdy", DW'(rdy2), DW'(1));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_flush_vld", DW'(vld2), DW'(0));
    end

`ifdef PIPE_STAGE_BUF_STATS_EN
    // Statistics on the STAGES=1, CNT_W=4 instance
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i + 1), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("xfer_cnt3", DW'(xfer1), DW'(3));
    chk("stall_cnt0", DW'(stall1), DW'(0));
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", DW'(stall1), DW'(15));
    chk("xfer_hold", DW'(xfer1), DW'(3));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("flush_stall_kept", DW'(stall1), DW'(15));
    chk("flush_xfer_kept", DW'(xfer1), DW'(3));
    chk("flush_stats_vld", DW'(vld1), DW'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_buf
`default_nettype wire
